// File: rtl/window_sum_pkg.sv
// window_sum_pkg: shared sizing helpers for the sliding-window sum block
package window_sum_pkg;
  localparam int N_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int W_DEF = 2 ** N_DEF;
  function automatic int sum_w(input int dw, input int n);
    return dw + n;
  endfunction
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction
  function automatic int win_len(input int n);
    return 2 ** n;
  endfunction
endpackage

// File: rtl/window_sum_ctrl_delay.sv
// sample_delay_line: W-stage shift register with enable and synchronous zeroing
module sample_delay_line
  import window_sum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q_oldest
);
  localparam int W = win_len(N);
  logic [DW-1:0] sr [W];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < W; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < W; i++) sr[i] <= sr[i-1];
    end
  end
  assign q_oldest = sr[W-1];
endmodule

// File: rtl/window_sum_ctrl.sv
// window_sum_ctrl: handshaked running window sum; WINDOW_SUM_AVG_EN outputs the mean instead
module window_sum_ctrl
  import window_sum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW+N-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            filled,
  output logic [N:0]      fill_count
);
  localparam int W = win_len(N);
  localparam int SW = sum_w(DW, N);
  localparam int CW = cnt_w(N);
  logic [DW-1:0] oldest;
  logic [SW-1:0] sum, sum_next, res;
  logic acc, load;
  assign in_ready = !clear && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign sum_next = sum + SW'(in_data) - SW'(oldest);
  assign load = acc && (fill_count >= CW'(W - 1));
  assign filled = fill_count == CW'(W);
`ifdef WINDOW_SUM_AVG_EN
  assign res = sum_next >> N;
`else
  assign res = sum_next;
`endif
  sample_delay_line #(.N(N), .DW(DW)) u_dl (
    .clk(clk), .rst(rst), .clr(clear), .en(acc), .d(in_data), .q_oldest(oldest)
  );
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
      fill_count <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      if (acc) begin
        sum <= sum_next;
        fill_count <= filled ? fill_count : fill_count + 1'b1;
      end
      if (load) begin
        out_data <= res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_sum_ctrl.sv
// tb_window_sum_ctrl: scoreboard bench for window_sum_ctrl at N=2, DW=8
`timescale 1ns/1ps
module tb_window_sum_ctrl;
  localparam int N = 2;
  localparam int DW = 8;
  localparam int W = 4;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = 0;
  logic in_ready, out_valid, filled;
  logic [DW+N-1:0] out_data;
  logic [N:0] fill_count;
  int checks = 0, errors = 0;
  int win[$];
  int exp_q[$];

  window_sum_ctrl #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .filled(filled), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  function automatic int expv(input int s);
`ifdef WINDOW_SUM_AVG_EN
    return s >> N;
`else
    return s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst || clear) begin
        win.delete();
        exp_q.delete();
      end else begin
        checks++;
        if (int'(fill_count) !== win.size()) begin
          errors++;
          $display("FAIL sb_fill_count: got %0d want %0d", fill_count, win.size());
        end
        if (out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_output: got %0d want none", out_data);
          end else if (int'(out_data) !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_out_data: got %0d want %0d", out_data, exp_q[0]);
          end
          if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          int s;
          win.push_back(int'(in_data));
          if (win.size() > W) void'(win.pop_front());
          if (win.size() == W) begin
            s = 0;
            foreach (win[i]) s += win[i];
            exp_q.push_back(expv(s));
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || fill_count !== '0 || filled !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%0b d=%0d fc=%0d f=%0b want 0 0 0 0", out_valid, out_data, fill_count, filled);
    end
  endtask

  task automatic test_fill();
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1;
      in_data = DW'(i);
      tick();
      if (i < 4) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_no_output: sample %0d got out_valid=%0b want 0", i, out_valid);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || int'(out_data) !== expv(10) || fill_count !== 3'd4 || filled !== 1'b1) begin
      errors++;
      $display("FAIL fill_first: got v=%0b d=%0d fc=%0d f=%0b want 1 %0d 4 1", out_valid, out_data, fill_count, filled, expv(10));
    end
  endtask

  task automatic test_slide();
    int sv[2] = '{5, 6};
    int ev[2] = '{14, 18};
    for (int i = 0; i < 2; i++) begin
      in_data = DW'(sv[i]);
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_data) !== expv(ev[i]) || fill_count !== 3'd4) begin
        errors++;
        $display("FAIL slide: got v=%0b d=%0d fc=%0d want 1 %0d 4", out_valid, out_data, fill_count, expv(ev[i]));
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    clear = 1;
    tick();
    clear = 0;
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1;
      in_data = DW'(i);
      if (i == 4) out_ready = 0;
      tick();
    end
    in_data = 5;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || int'(out_data) !== expv(10)) begin
        errors++;
        $display("FAIL stall: cycle %0d got rdy=%0b v=%0b d=%0d want 0 1 %0d", c, in_ready, out_valid, out_data, expv(10));
      end
      tick();
    end
    out_ready = 1;
    tick();
    checks++;
    if (int'(out_data) !== expv(14)) begin
      errors++;
      $display("FAIL release_first: got %0d want %0d", out_data, expv(14));
    end
    in_data = 6;
    tick();
    checks++;
    if (int'(out_data) !== expv(18)) begin
      errors++;
      $display("FAIL release_second: got %0d want %0d", out_data, expv(18));
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_max();
    clear = 1;
    tick();
    clear = 0;
    out_ready = 1;
    in_valid = 1;
    in_data = 8'd255;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b1 || int'(out_data) !== expv(1020)) begin
      errors++;
      $display("FAIL max_sum: got v=%0b d=%0d want 1 %0d", out_valid, out_data, expv(1020));
    end
    in_data = 0;
    tick();
    checks++;
    if (int'(out_data) !== expv(765)) begin
      errors++;
      $display("FAIL max_drop: got %0d want %0d", out_data, expv(765));
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_restart(input bit use_rst);
    clear = 1;
    tick();
    clear = 0;
    out_ready = 1;
    in_valid = 1;
    in_data = 7;
    repeat (2) tick();
    in_data = 9;
    if (use_rst) rst = 1; else clear = 1;
    #1;
    if (!use_rst) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL clear_ready: got %0b want 0", in_ready);
      end
    end
    tick();
    rst = 0;
    clear = 0;
    in_valid = 0;
    checks++;
    if (fill_count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_state: rst=%0b got fc=%0d v=%0b want 0 0", use_rst, fill_count, out_valid);
    end
    in_valid = 1;
    in_data = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (int'(fill_count) !== i || out_valid !== (i == 4)) begin
        errors++;
        $display("FAIL restart_fill: rst=%0b got fc=%0d v=%0b want %0d %0b", use_rst, fill_count, out_valid, i, i == 4);
      end
    end
    in_valid = 0;
    checks++;
    if (int'(out_data) !== expv(4)) begin
      errors++;
      $display("FAIL restart_out: rst=%0b got %0d want %0d", use_rst, out_data, expv(4));
    end
    tick();
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_fill();
    test_slide();
    test_backpressure();
    test_max();
    test_restart(1'b0);
    test_restart(1'b1);
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got %0d pending v=%0b want 0 0", exp_q.size(), out_valid);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
